// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared AXI types for the ysyx_24110006 crossbar: response codes,
// FSM state encodings, target select and the address decoder.
package ysyx_24110006_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE, R_ADDR, R_DATA, R_ERR
    } rstate_e;

    typedef enum logic [2:0] {
        W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR_DATA, W_ERR_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        TGT_MEM, TGT_CLINT, TGT_ERR
    } tgt_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_t;

    // CLINT is checked first so it wins any overlap with the memory window
    function automatic tgt_e decode(
        input logic [31:0] addr,
        input logic [31:0] mem_base,
        input logic [31:0] mem_mask,
        input logic [31:0] clint_base,
        input logic [31:0] clint_mask
    );
        if ((addr & clint_mask) == clint_base) return TGT_CLINT;
        if ((addr & mem_mask) == mem_base) return TGT_MEM;
        return TGT_ERR;
    endfunction

endpackage

// File: rtl/ysyx_24110006_xbar_if.sv
// AXI4 bus bundle (AR/R/AW/W/B) used for the upstream port and
// both downstream slave ports of the crossbar.
interface ysyx_24110006_xbar_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wlast;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic [3:0]  bid;
    logic        bready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst, rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst,
        output wdata, wstrb, wvalid, wlast, bready,
        input  arready, rdata, rvalid, rresp, rid, rlast,
        input  awready, wready, bresp, bvalid, bid
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst,
        input  wdata, wstrb, wvalid, wlast, bready,
        output arready, rdata, rvalid, rresp, rid, rlast,
        output awready, wready, bresp, bvalid, bid
    );
endinterface

// File: rtl/ysyx_24110006_xbar_decerr.sv
// DECERR responder shared by both paths: counts error read beats
// down from len and generates the error R and B channel values.
module ysyx_24110006_xbar_decerr
    import ysyx_24110006_axi_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       r_load,
    input  logic [7:0] r_len,
    input  logic       r_act,
    input  logic       r_ready,
    input  logic       b_act,
    output logic       r_valid,
    output logic       r_last,
    output logic [1:0] r_resp,
    output logic       b_valid,
    output logic [1:0] b_resp
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (r_load) cnt_d = r_len;
        else if (r_act && r_ready && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    assign r_valid = r_act;
    assign r_last  = r_act && (cnt_q == 8'd0);
    assign r_resp  = r_act ? RESP_DECERR : RESP_OKAY;
    assign b_valid = b_act;
    assign b_resp  = b_act ? RESP_DECERR : RESP_OKAY;
endmodule

// File: rtl/ysyx_24110006_xbar.sv
// AXI4 1-to-2 crossbar: routes reads/writes to memory bus (s0) or
// CLINT (s1) by address; unmapped addresses get DECERR internally.
module ysyx_24110006_xbar #(
    parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [31:0] MEM_MASK   = 32'hF000_0000,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic i_clock,
    input  logic i_reset,
    ysyx_24110006_xbar_if.slave  up,
    ysyx_24110006_xbar_if.master s0,
    ysyx_24110006_xbar_if.master s1
);
    import ysyx_24110006_axi_pkg::*;

    rstate_e rs_q, rs_d;
    wstate_e ws_q, ws_d;
    tgt_e    rt_q, rt_d, wt_q, wt_d;
    tgt_e    r_dec, w_dec;
    ax_t     ar_q, ar_d, aw_q, aw_d;
    logic    r_load;
    logic    e_rvalid, e_rlast, e_bvalid;
    logic [1:0] e_rresp, e_bresp;

    logic        sr_arready, sr_rvalid, sr_rlast;
    logic [31:0] sr_rdata;
    logic [1:0]  sr_rresp;
    logic [3:0]  sr_rid;
    logic        sw_awready, sw_wready, sw_bvalid;
    logic [1:0]  sw_bresp;
    logic [3:0]  sw_bid;

    assign r_dec = decode(up.araddr, MEM_BASE, MEM_MASK, CLINT_BASE, CLINT_MASK);
    assign w_dec = decode(up.awaddr, MEM_BASE, MEM_MASK, CLINT_BASE, CLINT_MASK);

    always_comb begin
        {sr_arready, sr_rvalid, sr_rlast, sr_rdata, sr_rresp, sr_rid} = '0;
        if (rt_q == TGT_MEM)
            {sr_arready, sr_rvalid, sr_rlast, sr_rdata, sr_rresp, sr_rid} =
                {s0.arready, s0.rvalid, s0.rlast, s0.rdata, s0.rresp, s0.rid};
        else if (rt_q == TGT_CLINT)
            {sr_arready, sr_rvalid, sr_rlast, sr_rdata, sr_rresp, sr_rid} =
                {s1.arready, s1.rvalid, s1.rlast, s1.rdata, s1.rresp, s1.rid};
    end

    always_comb begin
        {sw_awready, sw_wready, sw_bvalid, sw_bresp, sw_bid} = '0;
        if (wt_q == TGT_MEM)
            {sw_awready, sw_wready, sw_bvalid, sw_bresp, sw_bid} =
                {s0.awready, s0.wready, s0.bvalid, s0.bresp, s0.bid};
        else if (wt_q == TGT_CLINT)
            {sw_awready, sw_wready, sw_bvalid, sw_bresp, sw_bid} =
                {s1.awready, s1.wready, s1.bvalid, s1.bresp, s1.bid};
    end

    always_comb begin
        rs_d   = rs_q;
        rt_d   = rt_q;
        ar_d   = ar_q;
        r_load = 1'b0;
        unique case (rs_q)
            R_IDLE: if (up.arvalid) begin
                ar_d   = {up.araddr, up.arid, up.arlen, up.arsize, up.arburst};
                rt_d   = r_dec;
                r_load = (r_dec == TGT_ERR);
                rs_d   = r_load ? R_ERR : R_ADDR;
            end
            R_ADDR: if (sr_arready) rs_d = R_DATA;
            R_DATA: if (sr_rvalid && up.rready && sr_rlast) rs_d = R_IDLE;
            R_ERR:  if (up.rready && e_rlast) rs_d = R_IDLE;
            default: rs_d = R_IDLE;
        endcase
    end

    always_comb begin
        ws_d = ws_q;
        wt_d = wt_q;
        aw_d = aw_q;
        unique case (ws_q)
            W_IDLE: if (up.awvalid) begin
                aw_d = {up.awaddr, up.awid, up.awlen, up.awsize, up.awburst};
                wt_d = w_dec;
                ws_d = (w_dec == TGT_ERR) ? W_ERR_DATA : W_ADDR;
            end
            W_ADDR:     if (sw_awready) ws_d = W_DATA;
            W_DATA:     if (up.wvalid && sw_wready && up.wlast) ws_d = W_RESP;
            W_RESP:     if (sw_bvalid && up.bready) ws_d = W_IDLE;
            W_ERR_DATA: if (up.wvalid && up.wlast) ws_d = W_ERR_RESP;
            W_ERR_RESP: if (up.bready) ws_d = W_IDLE;
            default:    ws_d = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rs_q <= R_IDLE;
            ws_q <= W_IDLE;
            rt_q <= TGT_MEM;
            wt_q <= TGT_MEM;
            ar_q <= '0;
            aw_q <= '0;
        end else begin
            rs_q <= rs_d;
            ws_q <= ws_d;
            rt_q <= rt_d;
            wt_q <= wt_d;
            ar_q <= ar_d;
            aw_q <= aw_d;
        end
    end

    ysyx_24110006_xbar_decerr u_decerr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .r_load  (r_load),
        .r_len   (up.arlen),
        .r_act   (rs_q == R_ERR),
        .r_ready (up.rready),
        .b_act   (ws_q == W_ERR_RESP),
        .r_valid (e_rvalid),
        .r_last  (e_rlast),
        .r_resp  (e_rresp),
        .b_valid (e_bvalid),
        .b_resp  (e_bresp)
    );

    logic ra0, ra1, rd0, rd1, wa0, wa1, wd0, wd1, wr0, wr1;
    assign ra0 = (rs_q == R_ADDR) && (rt_q == TGT_MEM);
    assign ra1 = (rs_q == R_ADDR) && (rt_q == TGT_CLINT);
    assign rd0 = (rs_q == R_DATA) && (rt_q == TGT_MEM);
    assign rd1 = (rs_q == R_DATA) && (rt_q == TGT_CLINT);
    assign wa0 = (ws_q == W_ADDR) && (wt_q == TGT_MEM);
    assign wa1 = (ws_q == W_ADDR) && (wt_q == TGT_CLINT);
    assign wd0 = (ws_q == W_DATA) && (wt_q == TGT_MEM);
    assign wd1 = (ws_q == W_DATA) && (wt_q == TGT_CLINT);
    assign wr0 = (ws_q == W_RESP) && (wt_q == TGT_MEM);
    assign wr1 = (ws_q == W_RESP) && (wt_q == TGT_CLINT);

    // unselected slaves see all-zero request signals
    assign s0.arvalid = ra0;
    assign {s0.araddr, s0.arid, s0.arlen, s0.arsize, s0.arburst} = ra0 ? ar_q : '0;
    assign s0.rready  = rd0 & up.rready;
    assign s0.awvalid = wa0;
    assign {s0.awaddr, s0.awid, s0.awlen, s0.awsize, s0.awburst} = wa0 ? aw_q : '0;
    assign s0.wvalid  = wd0 & up.wvalid;
    assign {s0.wdata, s0.wstrb, s0.wlast} = wd0 ? {up.wdata, up.wstrb, up.wlast} : '0;
    assign s0.bready  = wr0 & up.bready;

    assign s1.arvalid = ra1;
    assign {s1.araddr, s1.arid, s1.arlen, s1.arsize, s1.arburst} = ra1 ? ar_q : '0;
    assign s1.rready  = rd1 & up.rready;
    assign s1.awvalid = wa1;
    assign {s1.awaddr, s1.awid, s1.awlen, s1.awsize, s1.awburst} = wa1 ? aw_q : '0;
    assign s1.wvalid  = wd1 & up.wvalid;
    assign {s1.wdata, s1.wstrb, s1.wlast} = wd1 ? {up.wdata, up.wstrb, up.wlast} : '0;
    assign s1.bready  = wr1 & up.bready;

    assign up.arready = (rs_q == R_IDLE);
    assign up.awready = (ws_q == W_IDLE);
    assign up.wready  = ((ws_q == W_DATA) & sw_wready) | (ws_q == W_ERR_DATA);

    always_comb begin
        {up.rvalid, up.rdata, up.rresp, up.rid, up.rlast} = '0;
        unique case (rs_q)
            R_DATA:
                {up.rvalid, up.rdata, up.rresp, up.rid, up.rlast} =
                    {sr_rvalid, sr_rdata, sr_rresp, sr_rid, sr_rlast};
            R_ERR:
                {up.rvalid, up.rdata, up.rresp, up.rid, up.rlast} =
                    {e_rvalid, 32'd0, e_rresp, ar_q.id, e_rlast};
            default: ;
        endcase
    end

    always_comb begin
        {up.bvalid, up.bresp, up.bid} = '0;
        unique case (ws_q)
            W_RESP:     {up.bvalid, up.bresp, up.bid} = {sw_bvalid, sw_bresp, sw_bid};
            W_ERR_RESP: {up.bvalid, up.bresp, up.bid} = {e_bvalid, e_bresp, aw_q.id};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ysyx_24110006_xbar.sv
// Directed bench for the ysyx_24110006 crossbar: the bench plays the
// upstream master and both downstream slaves.
module tb_ysyx_24110006_xbar;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    int   ar0_n = 0, ar1_n = 0, aw0_n = 0, w0_n = 0;

    ysyx_24110006_xbar_if up ();
    ysyx_24110006_xbar_if m0 ();
    ysyx_24110006_xbar_if m1 ();

    ysyx_24110006_xbar dut (
        .i_clock (clk),
        .i_reset (rst),
        .up      (up),
        .s0      (m0),
        .s1      (m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m0.arvalid) ar0_n <= ar0_n + 1;
        if (m1.arvalid) ar1_n <= ar1_n + 1;
        if (m0.awvalid) aw0_n <= aw0_n + 1;
        if (m0.wvalid)  w0_n  <= w0_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_req(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len);
        up.araddr = a; up.arid = id; up.arlen = len;
        up.arsize = 3'd2; up.arburst = 2'b01; up.arvalid = 1'b1;
        #1;
        chk("arready_idle", {31'd0, up.arready}, 32'd1);
        tick();
        up.arvalid = 1'b0;
    endtask

    task automatic aw_req(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len);
        up.awaddr = a; up.awid = id; up.awlen = len;
        up.awsize = 3'd2; up.awburst = 2'b01; up.awvalid = 1'b1;
        #1;
        chk("awready_idle", {31'd0, up.awready}, 32'd1);
        tick();
        up.awvalid = 1'b0;
    endtask

    task automatic clr_slave_r();
        m0.rvalid = 0; m0.rlast = 0; m0.rdata = 0; m0.rresp = 0; m0.rid = 0;
        m1.rvalid = 0; m1.rlast = 0; m1.rdata = 0; m1.rresp = 0; m1.rid = 0;
    endtask

    initial begin
        int a0, a1, aw0, w0, n;
        logic done;
        rst = 1'b1;
        up.araddr = 0; up.arvalid = 0; up.arid = 0; up.arlen = 0;
        up.arsize = 0; up.arburst = 0; up.rready = 0;
        up.awaddr = 0; up.awvalid = 0; up.awid = 0; up.awlen = 0;
        up.awsize = 0; up.awburst = 0;
        up.wdata = 0; up.wstrb = 0; up.wvalid = 0; up.wlast = 0; up.bready = 0;
        m0.arready = 0; m0.awready = 0; m0.wready = 0;
        m0.bvalid = 0; m0.bresp = 0; m0.bid = 0;
        m1.arready = 0; m1.awready = 0; m1.wready = 0;
        m1.bvalid = 0; m1.bresp = 0; m1.bid = 0;
        clr_slave_r();
        tick(); tick();
        chk("rst_arready", {31'd0, up.arready}, 32'd1);
        chk("rst_awready", {31'd0, up.awready}, 32'd1);
        chk("rst_rvalid", {31'd0, up.rvalid}, 32'd0);
        chk("rst_bvalid", {31'd0, up.bvalid}, 32'd0);
        chk("rst_wready", {31'd0, up.wready}, 32'd0);
        chk("rst_arvalid0", {31'd0, m0.arvalid}, 32'd0);
        rst = 1'b0;
        tick();

        // read to slave 0, single beat
        a1 = ar1_n;
        ar_req(32'h8000_0010, 4'd2, 8'd0);
        #1;
        chk("t1_arvalid0", {31'd0, m0.arvalid}, 32'd1);
        chk("t1_araddr0", m0.araddr, 32'h8000_0010);
        chk("t1_arready_busy", {31'd0, up.arready}, 32'd0);
        m0.arready = 1'b1;
        tick();
        m0.arready = 1'b0;
        m0.rvalid = 1; m0.rdata = 32'hDEAD_BEEF; m0.rresp = 0;
        m0.rid = 4'd2; m0.rlast = 1; up.rready = 1;
        #1;
        chk("t1_rvalid", {31'd0, up.rvalid}, 32'd1);
        chk("t1_rdata", up.rdata, 32'hDEAD_BEEF);
        chk("t1_rresp", {30'd0, up.rresp}, 32'd0);
        chk("t1_rready0", {31'd0, m0.rready}, 32'd1);
        tick();
        clr_slave_r(); up.rready = 0;
        #1;
        chk("t1_rvalid_done", {31'd0, up.rvalid}, 32'd0);
        chk("t1_arvalid1_cnt", ar1_n - a1, 32'd0);
        tick();

        // read to slave 1, 4 beats with one idle gap
        a0 = ar0_n;
        ar_req(32'h0200_BFF8, 4'd1, 8'd3);
        #1;
        chk("t2_arvalid1", {31'd0, m1.arvalid}, 32'd1);
        chk("t2_arlen1", {24'd0, m1.arlen}, 32'd3);
        m1.arready = 1'b1;
        tick();
        m1.arready = 1'b0;
        up.rready = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                m1.rvalid = 0;
                #1;
                chk("t2_gap_rvalid", {31'd0, up.rvalid}, 32'd0);
                tick();
            end
            m1.rvalid = 1; m1.rdata = 32'h100 + i; m1.rid = 4'd1;
            m1.rlast = (i == 3);
            #1;
            chk("t2_rdata", up.rdata, 32'h100 + i);
            chk("t2_rlast", {31'd0, up.rlast}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        clr_slave_r(); up.rready = 0;
        #1;
        chk("t2_idle_after", {31'd0, up.arready}, 32'd1);
        chk("t2_arvalid0_cnt", ar0_n - a0, 32'd0);
        tick();

        // unmapped read, 3 DECERR beats with an rready stall
        a0 = ar0_n; a1 = ar1_n;
        ar_req(32'h1000_0000, 4'd5, 8'd2);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                up.rready = 0;
                tick();
            end
            up.rready = 1;
            #1;
            chk("t3_rvalid", {31'd0, up.rvalid}, 32'd1);
            chk("t3_rresp", {30'd0, up.rresp}, 32'd3);
            chk("t3_rid", {28'd0, up.rid}, 32'd5);
            chk("t3_rdata", up.rdata, 32'd0);
            chk("t3_rlast", {31'd0, up.rlast}, (i == 2) ? 32'd1 : 32'd0);
            tick();
        end
        up.rready = 0;
        #1;
        chk("t3_rvalid_done", {31'd0, up.rvalid}, 32'd0);
        chk("t3_no_arvalid", (ar0_n - a0) + (ar1_n - a1), 32'd0);
        tick();

        // write to slave 1
        aw0 = aw0_n; w0 = w0_n;
        aw_req(32'h0200_4000, 4'd3, 8'd0);
        #1;
        chk("t4_awvalid1", {31'd0, m1.awvalid}, 32'd1);
        chk("t4_awaddr1", m1.awaddr, 32'h0200_4000);
        m1.awready = 1;
        tick();
        m1.awready = 0;
        up.wvalid = 1; up.wdata = 32'h1; up.wstrb = 4'hF; up.wlast = 1;
        m1.wready = 1;
        #1;
        chk("t4_wvalid1", {31'd0, m1.wvalid}, 32'd1);
        chk("t4_wdata1", m1.wdata, 32'h1);
        chk("t4_wready_up", {31'd0, up.wready}, 32'd1);
        tick();
        up.wvalid = 0; up.wlast = 0; m1.wready = 0;
        m1.bvalid = 1; m1.bresp = 0; m1.bid = 4'd3; up.bready = 1;
        #1;
        chk("t4_bvalid", {31'd0, up.bvalid}, 32'd1);
        chk("t4_bresp", {30'd0, up.bresp}, 32'd0);
        chk("t4_bid", {28'd0, up.bid}, 32'd3);
        tick();
        m1.bvalid = 0; up.bready = 0;
        #1;
        chk("t4_bvalid_done", {31'd0, up.bvalid}, 32'd0);
        chk("t4_s0_quiet", (aw0_n - aw0) + (w0_n - w0), 32'd0);
        tick();

        // concurrent read to slave 0 and unmapped 2-beat write
        aw0 = aw0_n; w0 = w0_n;
        up.araddr = 32'h8000_0100; up.arid = 4'd7; up.arlen = 8'd1;
        up.arvalid = 1;
        up.awaddr = 32'h4000_0000; up.awid = 4'd6; up.awlen = 8'd1;
        up.awvalid = 1;
        tick();
        up.arvalid = 0; up.awvalid = 0;
        m0.arready = 1;
        up.wvalid = 1; up.wdata = 32'h55; up.wlast = 0;
        #1;
        chk("t5_arvalid0", {31'd0, m0.arvalid}, 32'd1);
        chk("t5_err_wready", {31'd0, up.wready}, 32'd1);
        tick();
        m0.arready = 0;
        m0.rvalid = 1; m0.rdata = 32'hA0; m0.rid = 4'd7; m0.rlast = 0;
        up.rready = 0; up.wlast = 1;
        #1;
        chk("t5_rdata0", up.rdata, 32'hA0);
        chk("t5_rready_low", {31'd0, m0.rready}, 32'd0);
        tick();
        up.wvalid = 0; up.wlast = 0;
        up.rready = 1; up.bready = 0;
        #1;
        chk("t5_bvalid", {31'd0, up.bvalid}, 32'd1);
        chk("t5_bresp", {30'd0, up.bresp}, 32'd3);
        chk("t5_bid", {28'd0, up.bid}, 32'd6);
        tick();
        m0.rdata = 32'hA1; m0.rlast = 1;
        up.rready = 0; up.bready = 1;
        #1;
        chk("t5_rlast", {31'd0, up.rlast}, 32'd1);
        chk("t5_rdata1", up.rdata, 32'hA1);
        tick();
        up.bready = 0; up.rready = 1;
        #1;
        chk("t5_b_done", {31'd0, up.bvalid}, 32'd0);
        chk("t5_awready", {31'd0, up.awready}, 32'd1);
        chk("t5_rvalid_last", {31'd0, up.rvalid}, 32'd1);
        tick();
        clr_slave_r(); up.rready = 0;
        #1;
        chk("t5_arready", {31'd0, up.arready}, 32'd1);
        chk("t5_s0_no_write", (aw0_n - aw0) + (w0_n - w0), 32'd0);
        tick();

        // 256-beat DECERR read must not end early
        ar_req(32'h0000_0000, 4'd9, 8'd255);
        up.rready = 1;
        n = 0; done = 0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (up.rvalid) n++;
            if (up.rvalid && up.rlast) begin
                done = 1;
                break;
            end
            tick();
        end
        chk("t7_done", {31'd0, done}, 32'd1);
        chk("t7_beats", n, 32'd256);
        tick();
        up.rready = 0;
        #1;
        chk("t7_arready", {31'd0, up.arready}, 32'd1);
        tick();

        // reset during second beat of a slave 0 read
        ar_req(32'h8000_0000, 4'd4, 8'd3);
        m0.arready = 1;
        tick();
        m0.arready = 0;
        m0.rvalid = 1; m0.rdata = 32'hB0; m0.rlast = 0; up.rready = 1;
        tick();
        m0.rdata = 32'hB1;
        #1;
        chk("t6_beat2", up.rdata, 32'hB1);
        rst = 1;
        #1;
        chk("t6_rst_rvalid", {31'd0, up.rvalid}, 32'd0);
        chk("t6_rst_arready", {31'd0, up.arready}, 32'd1);
        chk("t6_rst_rready0", {31'd0, m0.rready}, 32'd0);
        tick();
        rst = 0;
        #1;
        chk("t6_post_rvalid", {31'd0, up.rvalid}, 32'd0);
        tick();
        #1;
        chk("t6_post_rvalid2", {31'd0, up.rvalid}, 32'd0);
        chk("t6_post_arready", {31'd0, up.arready}, 32'd1);
        clr_slave_r(); up.rready = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
